// File: rtl/pi_controller_mc_if.sv
// Bus bundle for the multi-channel PI controller: sample handshake,
// packed per-channel operands and gains, and the saturated command outputs.
interface pi_controller_mc_if #(
  parameter int N = 16,
  parameter int C = 2
);
  logic           inValid;
  logic           inReady;
  logic [C*N-1:0] refData;
  logic [C*N-1:0] fbData;
  logic [C*N-1:0] kp;
  logic [C*N-1:0] ki;
  logic [C*N-1:0] kaw;
  logic           clrInt;
  logic           outValid;
  logic [C*N-1:0] u;
  logic [C-1:0]   satFlag;

  modport master (
    output inValid, refData, fbData, kp, ki, kaw, clrInt,
    input  inReady, outValid, u, satFlag
  );

  modport slave (
    input  inValid, refData, fbData, kp, ki, kaw, clrInt,
    output inReady, outValid, u, satFlag
  );
endinterface

// File: rtl/pi_controller_mc.sv
// Time-multiplexed fixed-point PI controller for the FOC current loop.
// One shared multiplier is stepped through ERR/MULP/MULI/SAT/AW for every
// channel; back-calculation anti-windup pulls the integrator toward the
// saturated output whenever the command clips.
module pi_controller_mc #(
  parameter int N = 16,
  parameter int F = 12,
  parameter int C = 2,
  parameter int G = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  pi_controller_mc_if.slave       bus
);

  localparam int IW = N + G;
  localparam int EW = N + 1;
  localparam int MW = N + G + 2;
  localparam int PW = N + MW;
  localparam int WW = PW + 2;
  localparam int CW = (C > 1) ? $clog2(C) : 1;

  typedef enum logic [2:0] {IDLE, ERR, MULP, MULI, SAT, AW, DONE} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          chan_q, chan_d;
  logic signed [N-1:0]    ref_q [C];
  logic signed [N-1:0]    fb_q [C];
  logic signed [N-1:0]    kp_q [C];
  logic signed [N-1:0]    ki_q [C];
  logic signed [N-1:0]    kaw_q [C];
  logic signed [IW-1:0]   integ_q [C];
  logic signed [N-1:0]    uWork_q [C];
  logic [C-1:0]           satWork_q;
  logic signed [EW-1:0]   e_q;
  logic signed [IW-1:0]   p_q;
  logic signed [MW-1:0]   diff_q;
  logic [C*N-1:0]         u_q;
  logic [C-1:0]           sat_q;

  logic signed [N-1:0]    mulA;
  logic signed [MW-1:0]   mulB;
  logic signed [PW-1:0]   prod;
  logic signed [WW-1:0]   prodShift;
  logic signed [WW-1:0]   integSum;
  logic signed [WW-1:0]   vSum;
  logic signed [N-1:0]    uSat;

  function automatic logic signed [IW-1:0] clampI(input logic signed [WW-1:0] x);
    logic signed [WW-1:0] hi;
    logic signed [WW-1:0] lo;
    hi = {{(WW-IW+1){1'b0}}, {(IW-1){1'b1}}};
    lo = {{(WW-IW+1){1'b1}}, {(IW-1){1'b0}}};
    if (x > hi)      clampI = hi[IW-1:0];
    else if (x < lo) clampI = lo[IW-1:0];
    else             clampI = x[IW-1:0];
  endfunction

  function automatic logic signed [N-1:0] clampN(input logic signed [WW-1:0] x);
    logic signed [WW-1:0] hi;
    logic signed [WW-1:0] lo;
    hi = {{(WW-N+1){1'b0}}, {(N-1){1'b1}}};
    lo = {{(WW-N+1){1'b1}}, {(N-1){1'b0}}};
    if (x > hi)      clampN = hi[N-1:0];
    else if (x < lo) clampN = lo[N-1:0];
    else             clampN = x[N-1:0];
  endfunction

  // Route the current channel's gain and error (or back-calculation term) into the shared multiplier
  always_comb begin
    mulA = '0;
    mulB = '0;
    case (state_q)
      MULP: begin
        mulA = kp_q[chan_q];
        mulB = MW'(e_q);
      end
      MULI: begin
        mulA = ki_q[chan_q];
        mulB = MW'(e_q);
      end
      AW: begin
        mulA = kaw_q[chan_q];
        mulB = diff_q;
      end
      default: ;
    endcase
  end

  assign prod      = mulA * mulB;
  assign prodShift = WW'(prod) >>> F;
  assign integSum  = WW'(integ_q[chan_q]) + prodShift;
  assign vSum      = WW'(p_q) + WW'(integ_q[chan_q]);
  assign uSat      = clampN(vSum);

  // Sequence five steps per channel, then one DONE cycle that publishes the results
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    case (state_q)
      IDLE: begin
        if (bus.inValid) begin
          state_d = ERR;
          chan_d  = '0;
        end
      end
      ERR:  state_d = MULP;
      MULP: state_d = MULI;
      MULI: state_d = SAT;
      SAT:  state_d = AW;
      AW: begin
        if (chan_q == CW'(C-1)) begin
          state_d = DONE;
        end else begin
          state_d = ERR;
          chan_d  = chan_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers: operand capture, per-step arithmetic, integrator and output updates
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      chan_q    <= '0;
      e_q       <= '0;
      p_q       <= '0;
      diff_q    <= '0;
      u_q       <= '0;
      sat_q     <= '0;
      satWork_q <= '0;
      for (int k = 0; k < C; k++) begin
        ref_q[k]   <= '0;
        fb_q[k]    <= '0;
        kp_q[k]    <= '0;
        ki_q[k]    <= '0;
        kaw_q[k]   <= '0;
        integ_q[k] <= '0;
        uWork_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      case (state_q)
        IDLE: begin
          if (bus.clrInt) begin
            for (int k = 0; k < C; k++) integ_q[k] <= '0;
          end
          if (bus.inValid) begin
            for (int k = 0; k < C; k++) begin
              ref_q[k] <= bus.refData[k*N +: N];
              fb_q[k]  <= bus.fbData[k*N +: N];
              kp_q[k]  <= bus.kp[k*N +: N];
              ki_q[k]  <= bus.ki[k*N +: N];
              kaw_q[k] <= bus.kaw[k*N +: N];
            end
          end
        end
        ERR:  e_q <= EW'(ref_q[chan_q]) - EW'(fb_q[chan_q]);
        MULP: p_q <= clampI(prodShift);
        MULI: integ_q[chan_q] <= clampI(integSum);
        SAT: begin
          uWork_q[chan_q]   <= uSat;
          satWork_q[chan_q] <= (WW'(uSat) != vSum);
          diff_q            <= MW'(WW'(uSat) - vSum);
        end
        AW: begin
          if (satWork_q[chan_q]) integ_q[chan_q] <= clampI(integSum);
          if (chan_q == CW'(C-1)) begin
            for (int k = 0; k < C; k++) u_q[k*N +: N] <= uWork_q[k];
            sat_q <= satWork_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.inReady  = (state_q == IDLE);
  assign bus.outValid = (state_q == DONE);
  assign bus.u        = u_q;
  assign bus.satFlag  = sat_q;

endmodule

// File: tb/tb_pi_controller_mc.sv
// Self-checking bench for pi_controller_mc: directed scenarios from the
// controller's intended behaviour plus randomized samples, all compared
// against a plain-arithmetic reference model of the PI law.
module tb_pi_controller_mc;

  localparam int N = 16;
  localparam int F = 12;
  localparam int C = 2;
  localparam int G = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  int     refV [C];
  int     fbV [C];
  int     kpV [C];
  int     kiV [C];
  int     kawV [C];
  longint modelI [C];
  int     expU [C];
  logic [C-1:0] expSat;

  pi_controller_mc_if #(.N(N), .C(C)) bus ();

  pi_controller_mc #(.N(N), .F(F), .C(C), .G(G)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint satTo(input longint x, input int bits);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (bits-1)) - 1;
    lo = -(longint'(1) <<< (bits-1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic setChannels(input int r, input int f, input int p, input int i, input int aw);
    for (int k = 0; k < C; k++) begin
      refV[k] = r;
      fbV[k]  = f;
      kpV[k]  = p;
      kiV[k]  = i;
      kawV[k] = aw;
    end
  endtask

  task automatic modelSample(input bit clr);
    longint e, p, v, uu;
    if (clr) begin
      for (int k = 0; k < C; k++) modelI[k] = 0;
    end
    for (int k = 0; k < C; k++) begin
      e = longint'(refV[k]) - longint'(fbV[k]);
      p = satTo((longint'(kpV[k]) * e) >>> F, N+G);
      modelI[k] = satTo(modelI[k] + ((longint'(kiV[k]) * e) >>> F), N+G);
      v  = p + modelI[k];
      uu = satTo(v, N);
      expU[k]   = int'(uu);
      expSat[k] = (uu != v);
      if (uu != v) modelI[k] = satTo(modelI[k] + ((longint'(kawV[k]) * (uu - v)) >>> F), N+G);
    end
  endtask

  task automatic applyStimulus(input bit clr);
    @(negedge clk);
    for (int k = 0; k < C; k++) begin
      bus.refData[k*N +: N] = N'(refV[k]);
      bus.fbData[k*N +: N]  = N'(fbV[k]);
      bus.kp[k*N +: N]      = N'(kpV[k]);
      bus.ki[k*N +: N]      = N'(kiV[k]);
      bus.kaw[k*N +: N]     = N'(kawV[k]);
    end
    bus.clrInt  = clr;
    bus.inValid = 1'b1;
    @(posedge clk);
  endtask

  task automatic waitResult(input string tag, input bit busyClr);
    int cycles;
    bit seen;
    logic [N-1:0] expSlice;
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 40) begin
      @(negedge clk);
      cycles++;
      bus.inValid = 1'b0;
      bus.refData = (C*N)'($urandom);
      bus.fbData  = (C*N)'($urandom);
      bus.kp      = (C*N)'($urandom);
      bus.ki      = (C*N)'($urandom);
      bus.kaw     = (C*N)'($urandom);
      bus.clrInt  = (busyClr && cycles == 3);
      if (cycles == 1) checkOutput({tag, ".busy"}, 32'(bus.inReady), 32'd0);
      if (bus.outValid) seen = 1'b1;
    end
    checkOutput({tag, ".latency"}, 32'(cycles), 32'(5*C+1));
    if (seen) begin
      for (int k = 0; k < C; k++) begin
        expSlice = N'(expU[k]);
        checkOutput($sformatf("%s.u%0d", tag, k), 32'(bus.u[k*N +: N]), 32'(expSlice));
      end
      checkOutput({tag, ".sat"}, 32'(bus.satFlag), 32'(expSat));
    end
    @(negedge clk);
    checkOutput({tag, ".pulse"}, 32'(bus.outValid), 32'd0);
    checkOutput({tag, ".ready"}, 32'(bus.inReady), 32'd1);
  endtask

  task automatic runSample(input string tag, input bit clr, input bit busyClr);
    applyStimulus(clr);
    modelSample(clr);
    waitResult(tag, busyClr);
  endtask

  task automatic checkU0(input string tag, input int value);
    logic [N-1:0] v;
    v = N'(value);
    checkOutput(tag, 32'(bus.u[N-1:0]), 32'(v));
  endtask

  // Directed scenarios followed by randomized samples
  initial begin
    int pulses;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.inValid = 1'b0;
    bus.clrInt  = 1'b0;
    bus.refData = '0;
    bus.fbData  = '0;
    bus.kp      = '0;
    bus.ki      = '0;
    bus.kaw     = '0;
    for (int k = 0; k < C; k++) modelI[k] = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset.ready", 32'(bus.inReady), 32'd1);
    checkOutput("reset.valid", 32'(bus.outValid), 32'd0);
    checkOutput("reset.u", bus.u, 32'd0);
    checkOutput("reset.sat", 32'(bus.satFlag), 32'd0);
    rst = 1'b0;

    setChannels(1000, 0, 4096, 0, 0);
    runSample("pOnly", 1'b1, 1'b0);
    checkU0("pOnly.spec", 1000);

    setChannels(1000, 0, 0, 410, 0);
    runSample("iOnly1", 1'b0, 1'b0);
    checkU0("iOnly1.spec", 100);
    runSample("iOnly2", 1'b0, 1'b0);
    checkU0("iOnly2.spec", 200);
    runSample("iOnly3", 1'b0, 1'b0);
    checkU0("iOnly3.spec", 300);

    runSample("clrAccept", 1'b1, 1'b0);
    checkU0("clrAccept.spec", 100);
    runSample("clrBusy", 1'b0, 1'b1);
    checkU0("clrBusy.spec", 200);

    setChannels(32767, -32768, 32767, 0, 0);
    runSample("satHigh", 1'b1, 1'b0);
    checkU0("satHigh.spec", 32767);
    setChannels(-32768, 32767, 32767, 0, 0);
    runSample("satLow", 1'b1, 1'b0);
    checkU0("satLow.spec", -32768);

    setChannels(20000, 0, 0, 4096, 4096);
    runSample("aw1", 1'b1, 1'b0);
    checkU0("aw1.spec", 20000);
    for (int s = 0; s < 3; s++) begin
      runSample($sformatf("aw%0d", s+2), 1'b0, 1'b0);
      checkU0("awHold.spec", 32767);
    end
    setChannels(0, 0, 0, 4096, 4096);
    runSample("awRelease", 1'b0, 1'b0);
    checkU0("awRelease.spec", 32767);

    setChannels(500, 0, 4096, 0, 0);
    refV[1] = -500;
    runSample("chanIndep", 1'b1, 1'b0);
    checkU0("chanIndep.spec", 500);
    checkOutput("chanIndep.u1spec", 32'(bus.u[2*N-1:N]), 32'(16'hFE0C));

    setChannels(1000, 0, 0, 410, 0);
    applyStimulus(1'b0);
    @(negedge clk);
    bus.inValid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstMid.ready", 32'(bus.inReady), 32'd1);
    checkOutput("rstMid.u", bus.u, 32'd0);
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      if (bus.outValid) pulses++;
      @(negedge clk);
    end
    checkOutput("rstMid.noValid", 32'(pulses), 32'd0);
    for (int k = 0; k < C; k++) modelI[k] = 0;
    runSample("rstMid.next", 1'b0, 1'b0);
    checkU0("rstMid.next.spec", 100);

    for (int s = 0; s < 24; s++) begin
      for (int k = 0; k < C; k++) begin
        refV[k] = int'($urandom_range(0, 65535)) - 32768;
        fbV[k]  = int'($urandom_range(0, 65535)) - 32768;
        kpV[k]  = int'($urandom_range(0, 65535)) - 32768;
        kiV[k]  = int'($urandom_range(0, 65535)) - 32768;
        kawV[k] = int'($urandom_range(0, 65535)) - 32768;
      end
      runSample($sformatf("rand%0d", s), ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
